// File: rtl/ssd_value_formatter.sv
// ---------------------------------------------------------------------------
// ssd_value_formatter
//   Takes a binary value over a valid/ready handshake and produces eight
//   4-bit digits for the seven-segment display scanner. The value is shown
//   either as raw hex nibbles or as unsigned decimal. Decimal conversion uses
//   sequential double-dabble, one shift per clock. Digits stay stable between
//   conversions.
//
// Ports
//   clk       in   system clock (posedge)
//   rst       in   synchronous reset, active-high
//   in_valid  in   request qualifier for in_data / in_dec
//   in_ready  out  idle and able to accept (low while rst is high)
//   in_data   in   DATA_W-bit unsigned value
//   in_dec    in   1 = decimal conversion, 0 = hex nibbles
//   digit0..7 out  display digits, digit0 rightmost / least significant
//   ovf       out  last decimal value was >= 100_000_000 (digits show E)
//   done      out  one-cycle pulse when digits/ovf update
// ---------------------------------------------------------------------------
module ssd_value_formatter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_dec,
    output logic [3:0]        digit0,
    output logic [3:0]        digit1,
    output logic [3:0]        digit2,
    output logic [3:0]        digit3,
    output logic [3:0]        digit4,
    output logic [3:0]        digit5,
    output logic [3:0]        digit6,
    output logic [3:0]        digit7,
    output logic              ovf,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEX,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [5:0]  LAST_SHIFT = 6'(DATA_W - 1);
    localparam int unsigned ALIGN      = 32 - DATA_W;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_shreg;
    logic [39:0] r_bcd;
    logic [5:0]  r_cnt;
    logic [31:0] r_digits;
    logic        r_ovf;
    logic        r_done;

    logic        w_accept;
    logic [31:0] w_data_ext;
    logic [31:0] w_data_aligned;
    logic [39:0] w_bcd_adj;
    logic [39:0] w_bcd_next;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake
    // ------------------------------------------------------------------
    always_comb begin
        w_next   = r_state;
        in_ready = (r_state == S_IDLE) && !rst;
        w_accept = in_valid && (r_state == S_IDLE) && !rst;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = in_dec ? S_SHIFT : S_HEX;
                end
            end
            S_HEX:   w_next = S_IDLE;
            // r_cnt counts completed shifts; the shift taken at this edge
            // is the final one when DATA_W-1 have already been done.
            S_SHIFT: begin
                if (r_cnt == LAST_SHIFT) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Double-dabble step: add 3 to every BCD nibble >= 5, then shift
    // the next value bit in at the bottom.
    // ------------------------------------------------------------------
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int unsigned k = 0; k < 10; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) begin
                w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            end
        end
        w_bcd_next = (w_bcd_adj << 1) | {39'd0, r_shreg[31]};
    end

    // Decimal mode stores the value MSB-aligned so the next bit is always
    // r_shreg[31]; hex mode stores it zero-extended for direct nibble use.
    assign w_data_ext     = 32'(in_data);
    assign w_data_aligned = w_data_ext << ALIGN;

    // ------------------------------------------------------------------
    // Datapath and committed outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg  <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_digits <= '0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shreg <= in_dec ? w_data_aligned : w_data_ext;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_HEX: begin
                    r_digits <= r_shreg;
                    r_ovf    <= 1'b0;
                    r_done   <= 1'b1;
                end
                S_SHIFT: begin
                    r_bcd   <= w_bcd_next;
                    r_shreg <= r_shreg << 1;
                    r_cnt   <= r_cnt + 6'd1;
                end
                S_DONE: begin
                    // Nine or ten decimal digits do not fit the display.
                    if (r_bcd[39:32] != 8'd0) begin
                        r_digits <= {8{4'hE}};
                        r_ovf    <= 1'b1;
                    end else begin
                        r_digits <= r_bcd[31:0];
                        r_ovf    <= 1'b0;
                    end
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign digit0 = r_digits[3:0];
    assign digit1 = r_digits[7:4];
    assign digit2 = r_digits[11:8];
    assign digit3 = r_digits[15:12];
    assign digit4 = r_digits[19:16];
    assign digit5 = r_digits[23:20];
    assign digit6 = r_digits[27:24];
    assign digit7 = r_digits[31:28];
    assign ovf    = r_ovf;
    assign done   = r_done;

endmodule
